// File: rtl/reg_select_sequencer_if.sv
// Control-unit <-> register-select bus: IR capture, field selects, strobes,
// list-walk handshake and the per-register enables back to the register file.
interface reg_select_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 4
);
  localparam int NUM_REGS = 2**REG_ADDR_W;

  logic [DATA_WIDTH-1:0] IR_data;
  logic                  IR_load;
  logic                  Gra, Grb, Grc;
  logic                  Rin, Rout, BAout;
  logic                  list_start;
  logic                  list_step;
  logic [NUM_REGS-1:0]   reg_in;
  logic [NUM_REGS-1:0]   reg_out;
  logic [REG_ADDR_W-1:0] sel_addr;
  logic                  ba_zero;
  logic                  list_busy;
  logic                  list_done;
  logic [REG_ADDR_W:0]   list_count;
  logic                  sel_err;

  modport master (
    output IR_data, IR_load, Gra, Grb, Grc, Rin, Rout, BAout, list_start, list_step,
    input  reg_in, reg_out, sel_addr, ba_zero, list_busy, list_done, list_count, sel_err
  );

  modport slave (
    input  IR_data, IR_load, Gra, Grb, Grc, Rin, Rout, BAout, list_start, list_step,
    output reg_in, reg_out, sel_addr, ba_zero, list_busy, list_done, list_count, sel_err
  );
endinterface

// File: rtl/reg_select_sequencer.sv
// IR register-field select/decode with a register-list walker for multi-register
// load/store. Optional sticky select-conflict detector under `SEL_CONFLICT_EN.
module reg_select_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 4,
  parameter int RA_LSB     = 23,
  parameter int RB_LSB     = 19,
  parameter int RC_LSB     = 15,
  parameter int LIST_LSB   = 0
) (
  input  logic                   clock,
  input  logic                   clear,
  reg_select_sequencer_if.slave  bus
);
  localparam int NUM_REGS = 2**REG_ADDR_W;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  ir_q, ir_d;
  logic [NUM_REGS-1:0]    mask_q, mask_d;
  logic [REG_ADDR_W:0]    count_q, count_d;

  logic                   gr_any;
  logic [REG_ADDR_W-1:0]  fld_addr, low_idx, sel_addr;
  logic [NUM_REGS-1:0]    sel_oh, reg_in, reg_out, list_mask, mask_left;
  logic                   ba_zero;
  logic                   ir_unused;

  // Only the register fields and list mask are decoded; the rest of IR rides along.
  assign ir_unused = ^ir_q;
  assign list_mask = ir_q[LIST_LSB +: NUM_REGS];
  assign gr_any    = bus.Gra | bus.Grb | bus.Grc;

  always_comb begin
    fld_addr = '0;
    if (bus.Gra)      fld_addr = ir_q[RA_LSB +: REG_ADDR_W];
    else if (bus.Grb) fld_addr = ir_q[RB_LSB +: REG_ADDR_W];
    else if (bus.Grc) fld_addr = ir_q[RC_LSB +: REG_ADDR_W];
  end

  // Downward scan so the last hit is the lowest set bit.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_REGS-1; i >= 0; i--)
      if (mask_q[i]) low_idx = REG_ADDR_W'(i);
  end

  always_comb begin
    sel_addr = '0;
    reg_in   = '0;
    reg_out  = '0;
    ba_zero  = 1'b0;
    sel_oh   = '0;
    case (state_q)
      IDLE: begin
        sel_addr         = fld_addr;
        sel_oh[fld_addr] = 1'b1;
        ba_zero          = bus.BAout & ~bus.Rout & gr_any & (fld_addr == '0);
        if (bus.Rin & gr_any)                             reg_in  = sel_oh;
        if ((bus.Rout | bus.BAout) & gr_any & ~ba_zero)   reg_out = sel_oh;
      end
      RUN: begin
        sel_addr        = low_idx;
        sel_oh[low_idx] = 1'b1;
        if (bus.Rin)  reg_in  = sel_oh;
        if (bus.Rout) reg_out = sel_oh;
      end
      default: ;
    endcase
  end

  assign mask_left = mask_q & ~sel_oh;

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    mask_d  = mask_q;
    count_d = count_q;
    if (bus.IR_load && state_q != RUN) ir_d = bus.IR_data;
    case (state_q)
      IDLE: if (bus.list_start) begin
        mask_d  = list_mask;
        count_d = '0;
        state_d = (list_mask == '0) ? DONE : RUN;
      end
      RUN: if (bus.list_step) begin
        mask_d  = mask_left;
        count_d = count_q + 1'b1;
        if (mask_left == '0) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= IDLE;
      ir_q    <= '0;
      mask_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      mask_q  <= mask_d;
      count_q <= count_d;
    end
  end

`ifdef SEL_CONFLICT_EN
  logic sel_err_q, sel_err_d;
  logic conflict;

  assign conflict = (state_q == IDLE) &&
                    ((bus.Gra & bus.Grb) | (bus.Gra & bus.Grc) | (bus.Grb & bus.Grc) |
                     (bus.Rin & bus.Rout & gr_any));

  always_comb begin
    sel_err_d = sel_err_q | conflict;
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) sel_err_q <= 1'b0;
    else        sel_err_q <= sel_err_d;
  end

  assign bus.sel_err = sel_err_q;
`else
  assign bus.sel_err = 1'b0;
`endif

  assign bus.reg_in     = reg_in;
  assign bus.reg_out    = reg_out;
  assign bus.sel_addr   = sel_addr;
  assign bus.ba_zero    = ba_zero;
  assign bus.list_busy  = (state_q == RUN);
  assign bus.list_done  = (state_q == DONE);
  assign bus.list_count = count_q;
endmodule

// File: tb/tb_reg_select_sequencer.sv
// Self-checking bench for reg_select_sequencer: single-mode decode, BA zero,
// list walks against a queue of expected one-hot enables, reset mid-walk, conflicts.
module tb_reg_select_sequencer;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NR = 16;

  logic clock = 1'b0;
  logic clear;
  always #5 clock = ~clock;

  reg_select_sequencer_if #(.DATA_WIDTH(DW), .REG_ADDR_W(AW)) bus ();

  reg_select_sequencer #(
    .DATA_WIDTH(DW), .REG_ADDR_W(AW),
    .RA_LSB(23), .RB_LSB(19), .RC_LSB(15), .LIST_LSB(0)
  ) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [NR-1:0] exp_q[$];

  task automatic idle_inputs();
    bus.IR_data = '0; bus.IR_load = 1'b0;
    bus.Gra = 1'b0; bus.Grb = 1'b0; bus.Grc = 1'b0;
    bus.Rin = 1'b0; bus.Rout = 1'b0; bus.BAout = 1'b0;
    bus.list_start = 1'b0; bus.list_step = 1'b0;
  endtask

  task automatic load_ir(input logic [DW-1:0] v);
    bus.IR_data = v; bus.IR_load = 1'b1;
    @(negedge clock);
    bus.IR_load = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b0;
    idle_inputs();
    @(negedge clock);
    checks++; if (bus.reg_in !== '0)     begin failures++; $display("FAIL rst_reg_in got=%h exp=0", bus.reg_in); end
    checks++; if (bus.reg_out !== '0)    begin failures++; $display("FAIL rst_reg_out got=%h exp=0", bus.reg_out); end
    checks++; if (bus.sel_addr !== '0)   begin failures++; $display("FAIL rst_sel_addr got=%h exp=0", bus.sel_addr); end
    checks++; if (bus.ba_zero !== 1'b0)  begin failures++; $display("FAIL rst_ba_zero got=%b exp=0", bus.ba_zero); end
    checks++; if (bus.list_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", bus.list_busy); end
    checks++; if (bus.list_done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", bus.list_done); end
    checks++; if (bus.list_count !== '0) begin failures++; $display("FAIL rst_count got=%0d exp=0", bus.list_count); end
    checks++; if (bus.sel_err !== 1'b0)  begin failures++; $display("FAIL rst_sel_err got=%b exp=0", bus.sel_err); end
    clear = 1'b1;
    @(negedge clock);
    checks++; if (bus.reg_out !== '0 || bus.list_busy !== 1'b0)
      begin failures++; $display("FAIL idle_after_rst reg_out=%h busy=%b exp=0/0", bus.reg_out, bus.list_busy); end
  endtask

  task automatic test_single();
    load_ir((32'd5 << 23) | (32'd9 << 19) | (32'd3 << 15));
    bus.Gra = 1'b1; bus.Grb = 1'b1; bus.Rout = 1'b1;
    #2;
    checks++; if (bus.sel_addr !== 4'd5)     begin failures++; $display("FAIL prio_sel got=%0d exp=5", bus.sel_addr); end
    checks++; if (bus.reg_out !== 16'h0020)  begin failures++; $display("FAIL prio_out got=%h exp=0020", bus.reg_out); end
    checks++; if (bus.reg_in !== 16'h0000)   begin failures++; $display("FAIL prio_in got=%h exp=0000", bus.reg_in); end
    bus.Gra = 1'b0; bus.Grb = 1'b0; bus.Grc = 1'b1; bus.Rout = 1'b0; bus.Rin = 1'b1;
    #2;
    checks++; if (bus.reg_in !== 16'h0008 || bus.reg_out !== 16'h0000)
      begin failures++; $display("FAIL grc_rin got=%h/%h exp=0008/0000", bus.reg_in, bus.reg_out); end
    bus.Grc = 1'b0;
    #2;
    checks++; if (bus.reg_in !== 16'h0000 || bus.sel_addr !== 4'd0)
      begin failures++; $display("FAIL no_gr got=%h sel=%0d exp=0000 sel=0", bus.reg_in, bus.sel_addr); end
    idle_inputs();
    @(negedge clock);
  endtask

  task automatic test_ba_zero();
    load_ir(32'd9 << 23);
    bus.Grb = 1'b1; bus.BAout = 1'b1;
    #2;
    checks++; if (bus.ba_zero !== 1'b1)     begin failures++; $display("FAIL ba_zero got=%b exp=1", bus.ba_zero); end
    checks++; if (bus.reg_out !== 16'h0000) begin failures++; $display("FAIL ba_out got=%h exp=0000", bus.reg_out); end
    bus.Rout = 1'b1;
    #2;
    checks++; if (bus.reg_out !== 16'h0001 || bus.ba_zero !== 1'b0)
      begin failures++; $display("FAIL rout_r0 got=%h ba=%b exp=0001 ba=0", bus.reg_out, bus.ba_zero); end
    idle_inputs();
    @(negedge clock);
  endtask

  // gap = idle cycles between steps; a stray list_start is thrown in on each gap.
  task automatic test_list_walk(input logic [NR-1:0] mask, input int gap);
    int n;
    load_ir({16'h0, mask});
    exp_q.delete();
    n = 0;
    for (int i = 0; i < NR; i++)
      if (mask[i]) begin exp_q.push_back(NR'(1) << i); n++; end
    bus.Rout = 1'b1; bus.list_start = 1'b1;
    @(negedge clock);
    bus.list_start = 1'b0;
    for (int k = 0; k < n; k++) begin
      for (int g = 0; g < gap; g++) begin
        checks++; if (bus.reg_out !== exp_q[0] || bus.list_busy !== 1'b1)
          begin failures++; $display("FAIL walk_hold k=%0d got=%h busy=%b exp=%h busy=1", k, bus.reg_out, bus.list_busy, exp_q[0]); end
        bus.list_start = 1'b1;
        @(negedge clock);
        bus.list_start = 1'b0;
      end
      checks++; if (bus.reg_out !== exp_q[0] || bus.list_count !== (AW+1)'(k))
        begin failures++; $display("FAIL walk_step k=%0d got=%h cnt=%0d exp=%h cnt=%0d", k, bus.reg_out, bus.list_count, exp_q[0], k); end
      bus.list_step = 1'b1;
      @(negedge clock);
      bus.list_step = 1'b0;
      void'(exp_q.pop_front());
    end
    checks++; if (bus.list_done !== 1'b1 || bus.list_busy !== 1'b0 || bus.list_count !== (AW+1)'(n))
      begin failures++; $display("FAIL walk_done done=%b busy=%b cnt=%0d exp=1/0/%0d", bus.list_done, bus.list_busy, bus.list_count, n); end
    bus.list_step = 1'b1;
    @(negedge clock);
    checks++; if (bus.list_done !== 1'b0 || bus.list_count !== (AW+1)'(n))
      begin failures++; $display("FAIL walk_pulse done=%b cnt=%0d exp=0/%0d", bus.list_done, bus.list_count, n); end
    @(negedge clock);
    bus.list_step = 1'b0;
    checks++; if (bus.list_count !== (AW+1)'(n) || bus.list_busy !== 1'b0)
      begin failures++; $display("FAIL idle_step cnt=%0d busy=%b exp=%0d/0", bus.list_count, bus.list_busy, n); end
    idle_inputs();
  endtask

  task automatic test_load_with_start();
    load_ir(32'h0000_0002);
    bus.Rout = 1'b1;
    bus.IR_data = 32'h0000_0010; bus.IR_load = 1'b1; bus.list_start = 1'b1;
    @(negedge clock);
    bus.list_start = 1'b0;
    checks++; if (bus.reg_out !== 16'h0002 || bus.list_busy !== 1'b1)
      begin failures++; $display("FAIL old_ir got=%h busy=%b exp=0002/1", bus.reg_out, bus.list_busy); end
    bus.IR_data = 32'h0000_0040; bus.list_step = 1'b1;
    @(negedge clock);
    bus.IR_load = 1'b0; bus.list_step = 1'b0;
    checks++; if (bus.list_done !== 1'b1 || bus.list_count !== 5'd1)
      begin failures++; $display("FAIL one_done done=%b cnt=%0d exp=1/1", bus.list_done, bus.list_count); end
    @(negedge clock);
    bus.list_start = 1'b1;
    @(negedge clock);
    bus.list_start = 1'b0;
    checks++; if (bus.reg_out !== 16'h0010)
      begin failures++; $display("FAIL busy_load got=%h exp=0010", bus.reg_out); end
    bus.list_step = 1'b1;
    @(negedge clock);
    idle_inputs();
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    int seen_done;
    load_ir(32'h0000_0007);
    bus.Rout = 1'b1; bus.list_start = 1'b1;
    @(negedge clock);
    bus.list_start = 1'b0; bus.list_step = 1'b1;
    @(negedge clock);
    bus.list_step = 1'b0;
    checks++; if (bus.list_count !== 5'd1 || bus.list_busy !== 1'b1)
      begin failures++; $display("FAIL mid_pre cnt=%0d busy=%b exp=1/1", bus.list_count, bus.list_busy); end
    #2 clear = 1'b0;
    #1;
    checks++; if (bus.list_busy !== 1'b0 || bus.list_count !== 5'd0 || bus.list_done !== 1'b0 || bus.reg_out !== '0)
      begin failures++; $display("FAIL mid_rst busy=%b cnt=%0d done=%b out=%h exp=0/0/0/0", bus.list_busy, bus.list_count, bus.list_done, bus.reg_out); end
    @(negedge clock);
    clear = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (bus.list_done !== 1'b0) seen_done++;
    end
    checks++; if (seen_done != 0)
      begin failures++; $display("FAIL mid_no_done pulses=%0d exp=0", seen_done); end
    idle_inputs();
  endtask

  task automatic test_conflict();
    logic exp_err;
`ifdef SEL_CONFLICT_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    clear = 1'b0;
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    checks++; if (bus.sel_err !== 1'b0) begin failures++; $display("FAIL err_pre got=%b exp=0", bus.sel_err); end
    bus.Gra = 1'b1; bus.Grc = 1'b1;
    @(negedge clock);
    bus.Gra = 1'b0; bus.Grc = 1'b0;
    checks++; if (bus.sel_err !== exp_err) begin failures++; $display("FAIL err_set got=%b exp=%b", bus.sel_err, exp_err); end
    repeat (3) @(negedge clock);
    checks++; if (bus.sel_err !== exp_err) begin failures++; $display("FAIL err_sticky got=%b exp=%b", bus.sel_err, exp_err); end
    clear = 1'b0;
    #1;
    checks++; if (bus.sel_err !== 1'b0) begin failures++; $display("FAIL err_clr got=%b exp=0", bus.sel_err); end
    @(negedge clock);
    clear = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_ba_zero();
    test_list_walk(16'h8105, 1);
    test_list_walk(16'hFFFF, 0);
    test_list_walk(16'h0000, 0);
    test_load_with_start();
    test_reset_mid();
    test_conflict();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reg_select_sequencer.md
Name: reg_select_sequencer

Overview:
- Parametrised successor to the IR register select/decode logic in the datapath.
- Latches the IR register fields and drives one-hot per-register in/out enables for NUM_REGS registers.
- Adds base-address zero handling and a sequential register-list mode that walks a bitmask one register per step, for multi-register load/store.
- Sits between the control unit and the register file.

Parameters:
- DATA_WIDTH, 32, IR width.
- REG_ADDR_W, 4, register address width; NUM_REGS = 2**REG_ADDR_W.
- RA_LSB, 23, LSB of the Ra field in IR.
- RB_LSB, 19, LSB of the Rb field in IR.
- RC_LSB, 15, LSB of the Rc field in IR.
- LIST_LSB, 0, LSB of the NUM_REGS-bit register-list mask in IR; requires LIST_LSB+NUM_REGS <= DATA_WIDTH.

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  asynchronous, active-low reset.
- IR_data  in  DATA_WIDTH  instruction word.
- IR_load  in  1  latch IR_data into ir_q on the rising edge.
- Gra, Grb, Grc  in  1 each  field selects.
- Rin, Rout, BAout  in  1 each  strobes from control.
- list_start  in  1  begin register-list walk.
- list_step  in  1  consumer accepted the current register; advance.
- reg_in  out  NUM_REGS  one-hot register write enables.
- reg_out  out  NUM_REGS  one-hot register read enables.
- sel_addr  out  REG_ADDR_W  currently selected register number.
- ba_zero  out  1  BAout on R0: bus must read as constant 0.
- list_busy  out  1  list walk in progress.
- list_done  out  1  one-cycle pulse at end of walk.
- list_count  out  REG_ADDR_W+1  registers transferred in the current or last walk.
- sel_err  out  1  sticky conflict flag (see Optional Feature).

Behaviour:
- Reset (clear=0, async):
  - ir_q=0, mask=0, state=IDLE, list_count=0, list_done=0, sel_err=0.
  - Outputs reg_in=0, reg_out=0, sel_addr=0, ba_zero=0, list_busy=0.
- IR_load:
  - ir_q <= IR_data on the edge; ignored while list_busy=1.
  - The selection decode uses ir_q, so it is valid in the cycle after the load.
- Single mode (state IDLE), combinational from ir_q:
  - Priority Gra > Grb > Grc, no OR-merging. sel_addr = selected field, or 0 if none asserted.
  - reg_in = Rin ? onehot(sel_addr) : 0, gated by at least one Gr asserted.
  - reg_out = (Rout|BAout) ? onehot(sel_addr) : 0, same gating.
  - Exception: BAout=1 with sel_addr=0 and Rout=0 gives reg_out=0 and ba_zero=1.
- List FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on list_start: mask <= ir_q[LIST_LSB +: NUM_REGS], list_count <= 0.
  - IDLE -> DONE on list_start if that mask is 0 (no RUN cycles).
  - RUN:
    - sel_addr = index of lowest set bit of mask; Gr inputs and ba_zero are ignored.
    - reg_in/reg_out = onehot(sel_addr) gated by Rin/Rout respectively.
    - On list_step: clear that mask bit, list_count += 1.
    - If the cleared bit was the last set bit -> DONE, otherwise stay in RUN.
    - Without list_step, the selection holds indefinitely.
  - DONE: list_done=1 for exactly one cycle, then IDLE. list_count holds until the next list_start or reset.
  - list_busy = (state==RUN).
- Boundaries and simultaneous events:
  - list_start while in RUN or DONE is ignored.
  - list_step while in IDLE is ignored.
  - list_start together with IR_load in IDLE uses the old ir_q.
  - Full mask (all ones) takes NUM_REGS steps; list_count = NUM_REGS.
  - Reset mid-walk returns the block to the reset values immediately, with no list_done pulse.

Optional Feature:
- Macro SEL_CONFLICT_EN.
- Defined: sel_err is set on any edge where, in IDLE, more than one of Gra/Grb/Grc is asserted, or Rin and Rout are both asserted with a Gr active. It stays set until reset.
- Not defined: sel_err is tied to 0 and no detection logic is built.

Test Plan:
- Reset then idle -> all outputs 0, including list_count=0.
- IR_load with Ra=5, Rb=9; then Gra=1, Grb=1, Rout=1 -> sel_addr=5, reg_out=16'h0020, reg_in=0.
- ir_q Rb=0; Grb=1, BAout=1 -> ba_zero=1, reg_out=0. Then Grb=1, Rout=1 -> reg_out=16'h0001, ba_zero=0.
- Mask 16'h8105, list_start, Rout=1, list_step every other cycle:
  - reg_out sequence 0x0001, 0x0004, 0x0100, 0x8000.
  - list_done pulses once after the 4th step; list_count=4.
- Mask 0, list_start -> no RUN cycles, list_done next cycle, list_count=0. Reset asserted during a 3-register walk after 1 step -> list_busy=0, list_count=0, no list_done.
- With SEL_CONFLICT_EN: Gra=1, Grc=1 for one cycle -> sel_err=1 and stays 1 until clear=0. Without the macro -> sel_err stays 0.
